// File: rtl/alu_mdu_pkg.sv
// Shared opcodes, FSM states and the magnitude helper for the alu_mdu execution unit.
package alu_mdu_pkg;

  localparam logic [3:0] OP_ADDU  = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_SUBU  = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1001;
  localparam logic [3:0] OP_SLL   = 4'b1010;
  localparam logic [3:0] OP_SRL   = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_MULT  = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_DIV   = 4'b1111;

  // Helper operates on a wide container; callers zero-extend and keep the low bits (2*WIDTH <= ABS_W).
  localparam int unsigned ABS_W = 128;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} md_state_t;

  // Two's-complement magnitude of v when neg is set; also used as a conditional negate.
  function automatic logic [ABS_W-1:0] twos_abs(input logic [ABS_W-1:0] v, input logic neg);
    return neg ? (~v + ABS_W'(1)) : v;
  endfunction

endpackage

// File: rtl/alu_mdu_md_iter.sv
// Radix-2 iterative multiply/divide datapath: 2*WIDTH accumulator plus step counter.
module md_iter
  import alu_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   src_i,
  input  logic [WIDTH-1:0]   opd_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               last_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               div_q;

  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     rem_c_w;
  logic [WIDTH:0]     diff_w;
  logic               ge_w;

  // acc = {HI, LO}: multiply shifts the partial sum right, divide shifts the remainder left.
  always_comb begin
    add_w   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    rem_c_w = acc_q[2*WIDTH-1:WIDTH-1];
    diff_w  = rem_c_w - {1'b0, opd_q};
    ge_w    = rem_c_w >= {1'b0, opd_q};
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      acc_d = {{WIDTH{1'b0}}, src_i};
      cnt_d = SHW'(WIDTH - 1);
    end else if (step_i) begin
      if (div_q) begin
        acc_d = {ge_w ? diff_w[WIDTH-1:0] : rem_c_w[WIDTH-1:0], acc_q[WIDTH-2:0], ge_w};
      end else begin
        acc_d = {add_w, acc_q[WIDTH-1:1]};
      end
      if (cnt_q != '0) cnt_d = cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      opd_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (load_i) begin
        opd_q <= opd_i;
        div_q <= div_i;
      end
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/alu_mdu.sv
// EX-stage execution unit: single-cycle ALU plus iterative MULT/DIV engine writing HI/LO.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluctr,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic sa_q, sb_q, bz_q, div_q;

  logic md_start, load, step, wr, last;
  logic a_neg, b_neg;
  logic [ABS_W-1:0] a_abs_w, b_abs_w, prod_w, quo_w, rem_w;
  logic [WIDTH-1:0] src_w, opd_w;
  logic [2*WIDTH-1:0] acc_w;
  logic [WIDTH-1:0] sum_w, sub_w;
  logic unused_bits;

  assign md_start = start & (aluctr[3:2] == 2'b11);
  assign a_neg    = aluctr[0] & a[WIDTH-1];
  assign b_neg    = aluctr[0] & b[WIDTH-1];
  assign a_abs_w  = twos_abs(ABS_W'(a), a_neg);
  assign b_abs_w  = twos_abs(ABS_W'(b), b_neg);
  // Dividend/multiplier go into LO of the accumulator; the other operand is held aside.
  assign src_w    = aluctr[1] ? a_abs_w[WIDTH-1:0] : b_abs_w[WIDTH-1:0];
  assign opd_w    = aluctr[1] ? b_abs_w[WIDTH-1:0] : a_abs_w[WIDTH-1:0];

  md_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_md_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .step_i (step),
    .div_i  (aluctr[1]),
    .src_i  (src_w),
    .opd_i  (opd_w),
    .acc_o  (acc_w),
    .last_o (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (md_start) state_d = CALC;
      CALC: if (last) state_d = SIGN;
      SIGN: state_d = DONE;
      DONE: state_d = md_start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load = md_start & ((state_q == IDLE) | (state_q == DONE));
    step = (state_q == CALC);
    wr   = (state_q == SIGN);
    busy = (state_q == CALC) | (state_q == SIGN);
    done = (state_q == DONE);
  end

  // Divide by zero leaves quotient all ones; remainder still takes the dividend sign, giving back a.
  always_comb begin
    prod_w = twos_abs(ABS_W'(acc_w), sa_q ^ sb_q);
    quo_w  = twos_abs(ABS_W'(acc_w[WIDTH-1:0]), (sa_q ^ sb_q) & ~bz_q);
    rem_w  = twos_abs(ABS_W'(acc_w[2*WIDTH-1:WIDTH]), sa_q);
    hi_d   = div_q ? rem_w[WIDTH-1:0] : prod_w[2*WIDTH-1:WIDTH];
    lo_d   = div_q ? quo_w[WIDTH-1:0] : prod_w[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      bz_q  <= 1'b0;
      div_q <= 1'b0;
    end else begin
      if (load) begin
        sa_q  <= a_neg;
        sb_q  <= b_neg;
        bz_q  <= ~|b;
        div_q <= aluctr[1];
      end
      if (wr) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
    end
  end

  assign sum_w = a + b;
  assign sub_w = a - b;

  always_comb begin
    result   = lo_q;
    overflow = 1'b0;
    case (aluctr)
      OP_ADDU: result = sum_w;
      OP_ADD: begin
        result   = sum_w;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) & (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      OP_SUBU: result = sub_w;
      OP_SUB: begin
        result   = sub_w;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) & (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLTU: result = WIDTH'(a < b);
      OP_SLT:  result = WIDTH'($signed(a) < $signed(b));
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLL:  result = a << b[SHW-1:0];
      OP_SRL:  result = a >> b[SHW-1:0];
      default: result = lo_q;
    endcase
  end

  assign zero = ~|result;
  assign hi   = hi_q;
  assign lo   = lo_q;

  assign unused_bits = ^{a_abs_w[ABS_W-1:WIDTH], b_abs_w[ABS_W-1:WIDTH], prod_w[ABS_W-1:2*WIDTH],
                         quo_w[ABS_W-1:WIDTH], rem_w[ABS_W-1:WIDTH]};

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: ALU vector table, MULT/DIV table, handshake and reset corner cases.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  logic        clk, rst_n, start;
  logic [31:0] a, b;
  logic [3:0]  aluctr;
  logic [31:0] result, hi, lo;
  logic        zero, overflow, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .aluctr(aluctr), .start(start),
    .result(result), .zero(zero), .overflow(overflow), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ov;
  } alu_vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } md_vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after an edge; leaves the bench one step into cycle 1 of the launched op.
  task automatic launch(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    aluctr = op;
    a      = av;
    b      = bv;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    aluctr = OP_AND;
  endtask

  task automatic watch(input string nm, input logic [31:0] ehi, input logic [31:0] elo,
                       input int inject_at, input bit chain,
                       input logic [3:0] op2, input logic [31:0] a2, input logic [31:0] b2);
    int done_cnt = 0;
    int done_at  = -1;
    int busy_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      if (busy !== (n <= 33)) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = n;
      end
      if (n == 34) begin
        chk({nm, ".hi"}, 64'(hi), 64'(ehi));
        chk({nm, ".lo"}, 64'(lo), 64'(elo));
        if (chain) begin
          launch(op2, a2, b2);
          break;
        end
      end
      if (n == inject_at) begin
        aluctr = OP_DIVU;
        a      = 32'd1;
        b      = 32'd1;
        start  = 1'b1;
      end
    end
    chk({nm, ".busy_bad_cycles"}, 64'(busy_bad), 64'(0));
    chk({nm, ".done_cycle"}, 64'(done_at), 64'(34));
    chk({nm, ".done_count"}, 64'(done_cnt), 64'(1));
  endtask

  alu_vec_t av[14];
  md_vec_t  mv[8];

  initial begin
    int dcnt;
    av[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    av[1]  = '{OP_ADDU, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
    av[2]  = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    av[3]  = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    av[4]  = '{OP_SUBU, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
    av[5]  = '{OP_OR,   32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b0, 1'b0};
    av[6]  = '{OP_AND,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0};
    av[7]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    av[8]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    av[9]  = '{OP_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0};
    av[10] = '{OP_SLL,  32'h00000001, 32'h00000023, 32'h00000008, 1'b0, 1'b0};
    av[11] = '{OP_XOR,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0, 1'b0};
    av[12] = '{OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
    av[13] = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};

    mv[0] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    mv[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    mv[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    mv[3] = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    mv[4] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    mv[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    mv[6] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    mv[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; aluctr = OP_ADDU;
    #12;
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    chk("rst.hi",   64'(hi),   64'(0));
    chk("rst.lo",   64'(lo),   64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      aluctr = av[i].op;
      a      = av[i].a;
      b      = av[i].b;
      #1;
      chk($sformatf("alu[%0d].result", i),   64'(result),   64'(av[i].res));
      chk($sformatf("alu[%0d].zero", i),     64'(zero),     64'(av[i].z));
      chk($sformatf("alu[%0d].overflow", i), 64'(overflow), 64'(av[i].ov));
    end

    // start with a non-MD code must not launch the engine
    @(posedge clk);
    #1;
    aluctr = OP_ADD;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    chk("nonmd_start.busy", 64'(busy), 64'(0));

    for (int i = 0; i < 8; i++) begin
      launch(mv[i].op, mv[i].a, mv[i].b);
      watch($sformatf("md[%0d]", i), mv[i].ehi, mv[i].elo, 0, 1'b0, OP_ADDU, '0, '0);
    end
    aluctr = OP_MULT;
    #1;
    chk("lo_read.result", 64'(result), 64'(0));
    chk("lo_read.zero",   64'(zero),   64'(1));
    chk("lo_read.hi",     64'(hi),     64'(32'h40000000));

    launch(OP_MULT, 32'hFFFFFFFD, 32'h00000005);
    watch("ignored_start", 32'hFFFFFFFF, 32'hFFFFFFF1, 10, 1'b0, OP_ADDU, '0, '0);

    launch(OP_MULTU, 32'hFFFFFFFF, 32'h00000002);
    watch("b2b_first", 32'h00000001, 32'hFFFFFFFE, 0, 1'b1, OP_DIVU, 32'd100, 32'd7);
    watch("b2b_second", 32'h00000002, 32'h0000000E, 0, 1'b0, OP_ADDU, '0, '0);
    aluctr = OP_DIVU;
    #1;
    chk("b2b.result_is_lo", 64'(result), 64'(32'h0000000E));

    launch(OP_DIV, 32'hFFFFFF9C, 32'h00000003);
    for (int n = 2; n <= 15; n++) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop_rst.busy", 64'(busy), 64'(0));
    chk("midop_rst.done", 64'(done), 64'(0));
    chk("midop_rst.hi",   64'(hi),   64'(0));
    chk("midop_rst.lo",   64'(lo),   64'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    chk("midop_rst.no_done_or_busy", 64'(dcnt), 64'(0));

    launch(OP_DIV, 32'hFFFFFF9C, 32'h00000003);
    watch("after_rst", 32'hFFFFFFFF, 32'hFFFFFFDF, 0, 1'b0, OP_ADDU, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
